// File: rtl/rcv_pkg.sv
// Shared types and helpers for the UART receive control unit.
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RECV,
        STOP_CHK,
        LOAD
    } state_t;

    // Baud-counter value one cycle before mid-bit is half_period(clks) - 1.
    function automatic int half_period(input int clks);
        return clks / 2;
    endfunction

endpackage

// File: rtl/rcv_timer.sv
// Baud counter and bit counter for the receiver. Marks the mid-bit strobe point
// and the end of each bit period.
module rcv_timer
    import rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BITS     = 9
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             enable,
    input  logic                             clear,
    output logic                             strobe_pt,
    output logic                             wrap,
    output logic [$clog2(NUM_BITS + 1)-1:0]  bit_cnt
);

    localparam int BC_W  = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(NUM_BITS + 1);
    localparam int HALF  = half_period(CLKS_PER_BIT);

    logic [BC_W-1:0] bc;

    assign strobe_pt = (bc == BC_W'(HALF - 1));
    assign wrap      = (bc == BC_W'(CLKS_PER_BIT - 1));

    // bit_cnt saturates at NUM_BITS; the FSM leaves RECV before it could wrap.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bc      <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            bc      <= '0;
            bit_cnt <= '0;
        end else if (enable) begin
            if (wrap) begin
                bc <= '0;
                if (bit_cnt != CNT_W'(NUM_BITS))
                    bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
                bc <= bc + BC_W'(1);
            end
        end
    end

endmodule

// File: rtl/rcv_ctrl.sv
// Receive control for the UART receiver: synchronizes the serial line, finds the
// start bit, paces the shift register, then loads the buffer or flags a framing error.
module rcv_ctrl
    import rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BITS     = 9
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic stop_bit,
    output logic shift_strobe,
    output logic sbc_clear,
    output logic load_buffer,
    output logic framing_error,
    output logic receiving
);

    localparam int CNT_W = $clog2(NUM_BITS + 1);

    state_t           state;
    state_t           state_next;
    logic             s1, s2, s3;
    logic             start_edge;
    logic             strobe_pt;
    logic             wrap;
    logic [CNT_W-1:0] bit_cnt;
    logic             timer_en;
    logic             timer_clr;

    // Synchronizer resets to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= serial_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start_edge = s3 & ~s2;
    assign timer_en   = (state == START) || (state == RECV);
    assign timer_clr  = (state == IDLE);

    rcv_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .NUM_BITS     (NUM_BITS)
    ) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .enable    (timer_en),
        .clear     (timer_clr),
        .strobe_pt (strobe_pt),
        .wrap      (wrap),
        .bit_cnt   (bit_cnt)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            sbc_clear     <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state     <= state_next;
            sbc_clear <= (state == IDLE) && start_edge;
            if ((state == IDLE) && start_edge)
                framing_error <= 1'b0;
            else if ((state == STOP_CHK) && !stop_bit)
                framing_error <= 1'b1;
        end
    end

    // A start bit that is high again at mid-bit is treated as line noise.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (start_edge) state_next = START;
            START: begin
                if (strobe_pt && s2)
                    state_next = IDLE;
                else if (wrap)
                    state_next = RECV;
            end
            RECV:     if (strobe_pt && (bit_cnt == CNT_W'(NUM_BITS))) state_next = STOP_CHK;
            STOP_CHK: state_next = stop_bit ? LOAD : IDLE;
            LOAD:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign shift_strobe = (state == RECV) && strobe_pt;
    assign load_buffer  = (state == LOAD);
    assign receiving    = (state != IDLE);

endmodule
